// File: rtl/neocore_pkg.sv
// Shared core types: the decoded-instruction record handed from decode to
// the issue queue, plus the default queue depth.
package neocore_pkg;

    typedef enum logic [2:0] {
        ITYPE_ALU    = 3'd0,
        ITYPE_MUL    = 3'd1,
        ITYPE_LOAD   = 3'd2,
        ITYPE_STORE  = 3'd3,
        ITYPE_BRANCH = 3'd4,
        ITYPE_JUMP   = 3'd5,
        ITYPE_SYS    = 3'd6,
        ITYPE_NOP    = 3'd7
    } inst_type_t;

    typedef struct packed {
        inst_type_t  itype;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  rd2;
        logic        rd_we;
        logic        rd2_we;
        logic [31:0] pc;
    } issue_entry_t;

    localparam int ISSUE_Q_DEPTH = 8;
    localparam int ISSUE_ENTRY_W = $bits(issue_entry_t);

endpackage

// File: rtl/issue_queue.sv
// Dual-slot in-order instruction queue between decode and dual issue.
// Presents the two oldest entries every cycle; pops 0/1/2 per issue decision.
module issue_queue
    import neocore_pkg::*;
#(
    parameter int DEPTH   = ISSUE_Q_DEPTH,
    parameter int ENTRY_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in0_valid,
    input  logic [ENTRY_W-1:0]         in0_data,
    input  logic                       in1_valid,
    input  logic [ENTRY_W-1:0]         in1_data,
    output logic                       in_ready,
    output logic                       out0_valid,
    output logic [ENTRY_W-1:0]         out0_data,
    output logic                       out1_valid,
    output logic [ENTRY_W-1:0]         out1_data,
    input  logic                       issue_inst0,
    input  logic                       issue_inst1,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [PTR_W-1:0]   head_plus1;
    logic [PTR_W-1:0]   tail_plus1;
    logic [CNT_W-1:0]   count_reg;
    logic [1:0]         pop_req;
    logic [1:0]         pop_amt;
    logic [1:0]         push_amt;
    logic [DEPTH-1:0]   wr0_sel;
    logic [DEPTH-1:0]   wr1_sel;

    assign head_plus1 = head_reg + PTR_W'(1);
    assign tail_plus1 = tail_reg + PTR_W'(1);

    // Outputs depend on registered state only; same-cycle pops never raise in_ready.
    assign in_ready   = (count_reg <= CNT_W'(DEPTH - 2));
    assign out0_valid = (count_reg != '0);
    assign out1_valid = (count_reg >= CNT_W'(2));
    assign out0_data  = mem_reg[head_reg];
    assign out1_data  = mem_reg[head_plus1];
    assign count      = count_reg;

    always_comb begin
        pop_req = issue_inst0 ? (issue_inst1 ? 2'd2 : 2'd1) : 2'd0;
        pop_amt = pop_req;
        if (CNT_W'(pop_req) > count_reg) begin
            pop_amt = count_reg[1:0];
        end
        push_amt = 2'd0;
        if (in_ready && in0_valid) begin
            push_amt = in1_valid ? 2'd2 : 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign wr0_sel[gi] = (push_amt != 2'd0) && (tail_reg == PTR_W'(gi));
            assign wr1_sel[gi] = (push_amt == 2'd2) && (tail_plus1 == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; only the bookkeeping is discarded.
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + PTR_W'(pop_amt);
            tail_reg  <= tail_reg + PTR_W'(push_amt);
            count_reg <= count_reg + CNT_W'(push_amt) - CNT_W'(pop_amt);
            for (int i = 0; i < DEPTH; i++) begin
                if (wr0_sel[i]) begin
                    mem_reg[i] <= in0_data;
                end else if (wr1_sel[i]) begin
                    mem_reg[i] <= in1_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_issue_queue;

    localparam int DEPTH   = 8;
    localparam int ENTRY_W = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               in0_valid;
    logic [ENTRY_W-1:0] in0_data;
    logic               in1_valid;
    logic [ENTRY_W-1:0] in1_data;
    logic               in_ready;
    logic               out0_valid;
    logic [ENTRY_W-1:0] out0_data;
    logic               out1_valid;
    logic [ENTRY_W-1:0] out1_data;
    logic               issue_inst0;
    logic               issue_inst1;
    logic               flush;
    logic [3:0]         count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ENTRY_W-1:0] model_q[$];

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_data(in1_data),
        .in_ready(in_ready),
        .out0_valid(out0_valid), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_data(out1_data),
        .issue_inst0(issue_inst0), .issue_inst1(issue_inst1),
        .flush(flush), .count(count)
    );

    task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_data = '0; in1_data = '0;
        issue_inst0 = 1'b0; issue_inst1 = 1'b0;
    endtask

    // Applies the current inputs for one clock, updates the model by the
    // queue's rules, then compares every visible output.
    task automatic tick(input string tag);
        int pop_n, push_n, sz;
        bit rdy;
        sz     = model_q.size();
        rdy    = (DEPTH - sz) >= 2;
        pop_n  = issue_inst0 ? (issue_inst1 ? 2 : 1) : 0;
        if (pop_n > sz) pop_n = sz;
        push_n = (rdy && in0_valid) ? (in1_valid ? 2 : 1) : 0;
        @(posedge clk);
        if (rst || flush) begin
            model_q.delete();
        end else begin
            repeat (pop_n) void'(model_q.pop_front());
            if (push_n >= 1) model_q.push_back(in0_data);
            if (push_n == 2) model_q.push_back(in1_data);
        end
        #1;
        sz = model_q.size();
        chk({tag, ".count"}, ENTRY_W'(count), ENTRY_W'(sz));
        chk({tag, ".out0_valid"}, ENTRY_W'(out0_valid), ENTRY_W'(sz >= 1));
        chk({tag, ".out1_valid"}, ENTRY_W'(out1_valid), ENTRY_W'(sz >= 2));
        chk({tag, ".in_ready"}, ENTRY_W'(in_ready), ENTRY_W'((DEPTH - sz) >= 2));
        if (sz >= 1) chk({tag, ".out0_data"}, out0_data, model_q[0]);
        if (sz >= 2) chk({tag, ".out1_data"}, out1_data, model_q[1]);
        $display("txn %-10s count=%0d in_ready=%0b out0=%0b:%0h out1=%0b:%0h",
                 tag, count, in_ready, out0_valid, out0_data, out1_valid, out1_data);
    endtask

    task automatic push2(input logic [ENTRY_W-1:0] a, input logic [ENTRY_W-1:0] b);
        in0_valid = 1'b1; in0_data = a;
        in1_valid = 1'b1; in1_data = b;
    endtask

    task automatic push1(input logic [ENTRY_W-1:0] a);
        in0_valid = 1'b1; in0_data = a;
        in1_valid = 1'b0;
    endtask

    task automatic pop(input int n);
        issue_inst0 = (n >= 1);
        issue_inst1 = (n >= 2);
    endtask

    initial begin
        idle_inputs();

        // Reset then idle
        rst = 1'b1;
        tick("reset");
        chk("reset.out0_data", out0_data, '0);
        chk("reset.out1_data", out1_data, '0);
        idle_inputs();
        pop(1);
        tick("pop_empty");
        tick("pop_empty2");

        // Dual push, single pops
        idle_inputs();
        push2(64'hA, 64'hB);
        tick("push_ab");
        chk("push_ab.out0", out0_data, 64'hA);
        chk("push_ab.out1", out1_data, 64'hB);
        idle_inputs();
        pop(1);
        tick("pop_a");
        chk("pop_a.out0", out0_data, 64'hB);
        pop(1);
        tick("pop_b");

        // Fill and backpressure
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            push2(64'h100 + 2 * i, 64'h101 + 2 * i);
            tick("fill");
        end
        chk("fill.count", ENTRY_W'(count), 64'd8);
        chk("fill.in_ready", ENTRY_W'(in_ready), 64'd0);
        push2(64'hDEAD, 64'hBEEF);
        tick("drop");
        pop(2);
        tick("drop_pop2");
        chk("drop_pop2.count", ENTRY_W'(count), 64'd6);
        chk("drop_pop2.out0", out0_data, 64'h102);

        // Wrap-around: steer head to index 7 with X@7, Y@0
        idle_inputs();
        flush = 1'b1;
        tick("flush0");
        flush = 1'b0;
        push2(64'h200, 64'h201);
        tick("w1");
        pop(2); push2(64'h202, 64'h203);
        tick("w2");
        pop(2); push2(64'h204, 64'h205);
        tick("w3");
        idle_inputs(); pop(2);
        tick("w4");
        idle_inputs(); push1(64'h206);
        tick("w5");
        push2(64'h0C7, 64'h0C0); pop(1);
        tick("wrap");
        chk("wrap.out0", out0_data, 64'h0C7);
        chk("wrap.out1", out1_data, 64'h0C0);
        idle_inputs(); pop(2);
        tick("wrap_pop2");

        // Simultaneous push 2 / pop 2 at count=4
        idle_inputs();
        push2(64'h300, 64'h301);
        tick("s1");
        push2(64'h302, 64'h303);
        tick("s2");
        push2(64'h304, 64'h305); pop(2);
        tick("s_pp");
        chk("s_pp.count", ENTRY_W'(count), 64'd4);
        chk("s_pp.out0", out0_data, 64'h302);

        // issue_inst1 alone is ignored
        idle_inputs();
        issue_inst1 = 1'b1;
        tick("inst1_only");

        // Flush at count=5 with a same-cycle push
        idle_inputs(); push1(64'h306);
        tick("to5");
        chk("to5.count", ENTRY_W'(count), 64'd5);
        push2(64'h400, 64'h401); pop(2); flush = 1'b1;
        tick("flush5");
        chk("flush5.out0_valid", ENTRY_W'(out0_valid), 64'd0);

        // Reset together with flush and push
        idle_inputs(); push2(64'h500, 64'h501);
        tick("pre_rst");
        push2(64'h502, 64'h503); flush = 1'b1; rst = 1'b1;
        tick("rst_flush");
        chk("rst_flush.out0_data", out0_data, '0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            rst         = ($urandom_range(99) == 0);
            flush       = ($urandom_range(49) == 0);
            in0_valid   = $urandom_range(3) != 0;
            in1_valid   = $urandom_range(1);
            in0_data    = {$urandom, $urandom};
            in1_data    = {$urandom, $urandom};
            issue_inst0 = $urandom_range(1);
            issue_inst1 = $urandom_range(1);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
